// File: rtl/ofmap_pkg.sv
// Shared constants and FSM state type for the ofmap writer.
// Default geometry: 4 channels x 8 bits per beat, 4 beats per word, 4-entry FIFO.
package ofmap_pkg;

  localparam int OUT_CH_D     = 4;
  localparam int BITWIDTH_D   = 8;
  localparam int PACK_D       = 4;
  localparam int FIFO_DEPTH_D = 4;

  localparam int BEAT_W     = OUT_CH_D * BITWIDTH_D;
  localparam int WORD_W     = PACK_D * BEAT_W;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH_D);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/ofmap_word_fifo.sv
// Synchronous packed-word FIFO with same-cycle push/pop.
// Reports full, empty and the number of free entries.
module ofmap_word_fifo
  import ofmap_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 1 << FIFO_PTR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign dout     = mem[rd_ptr];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign free_cnt = (PW+1)'(DEPTH) - count;

endmodule

// File: rtl/ofmap_writer.sv
// Packs postproc beats into SRAM words and streams them to the ofmap SRAM.
// Optional OFMAP_WRITER_STAT_EN adds a saturating stall_cycles counter.
module ofmap_writer
  import ofmap_pkg::*;
#(
  parameter int OUT_CH     = 4,
  parameter int BITWIDTH   = 8,
  parameter int PACK       = 4,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [CNT_W-1:0]                num_words,
  input  logic                            in_valid,
  input  logic [OUT_CH*BITWIDTH-1:0]      in_data,
  output logic                            in_stall,
  output logic                            sram_wen,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic [PACK*OUT_CH*BITWIDTH-1:0] sram_wdata,
  input  logic                            sram_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
`ifdef OFMAP_WRITER_STAT_EN
  ,
  output logic [31:0]                     stall_cycles
`endif
);

  localparam int BW = OUT_CH * BITWIDTH;
  localparam int WW = PACK * BW;
  localparam int CW = $clog2(PACK);
  localparam int FW = $clog2(FIFO_DEPTH);

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     beat_cnt;
  logic [CNT_W-1:0]  nw_q;
  logic [CNT_W-1:0]  words_pushed;
  logic [CNT_W-1:0]  words_written;
  logic [ADDR_W-1:0] base_q;
  logic [WW-1:0]     pack_q;
  logic [WW-1:0]     pack_n;

  logic          start_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic          last_wr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW:0]   free_cnt;

  assign start_ok = (state == IDLE) && start;
  assign pop      = !fifo_empty && sram_ready;
  assign accept   = (state == RUN) && in_valid &&
                    (words_pushed < nw_q) &&
                    (!fifo_full || pop);
  assign push     = accept && (beat_cnt == CW'(PACK-1));
  assign last_wr  = pop && (words_written + CNT_W'(1) == nw_q);

  // Incoming beat lands in its slot; slot 0 sits in the LSBs.
  always_comb begin
    pack_n = pack_q;
    pack_n[beat_cnt*BW +: BW] = in_data;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_wr) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      nw_q          <= '0;
      words_pushed  <= '0;
      words_written <= '0;
      base_q        <= '0;
      pack_q        <= '0;
      overflow      <= 1'b0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        base_q        <= base_addr;
        nw_q          <= num_words;
        beat_cnt      <= '0;
        words_pushed  <= '0;
        words_written <= '0;
      end else begin
        if (accept) begin
          pack_q   <= pack_n;
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (push) begin
          words_pushed <= words_pushed + 1'b1;
        end
        if (pop) begin
          words_written <= words_written + 1'b1;
        end
      end
      // A dropped beat wins over the clear from a same-cycle start.
      if (in_valid && !accept) begin
        overflow <= 1'b1;
      end else if (start_ok) begin
        overflow <= 1'b0;
      end
    end
  end

  ofmap_word_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      (pack_n),
    .dout     (sram_wdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .free_cnt (free_cnt)
  );

  assign sram_wen  = !fifo_empty;
  assign sram_addr = base_q + ADDR_W'(words_written);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign in_stall  = (state == RUN) && (free_cnt <= (FW+1)'(1));

`ifdef OFMAP_WRITER_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (start_ok) begin
      stall_cycles <= '0;
    end else if ((state == RUN) &&
                 (in_stall || (sram_wen && !sram_ready)) &&
                 (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed-plus-random bench for ofmap_writer with a word-level scoreboard.
// Build with +define+OFMAP_WRITER_STAT_EN to also check stall_cycles.
module tb_ofmap_writer;

  localparam int PACK  = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [15:0]  num_words = '0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         sram_ready = 1'b0;
  logic         in_stall;
  logic         sram_wen;
  logic [15:0]  sram_addr;
  logic [127:0] sram_wdata;
  logic         busy;
  logic         done;
  logic         overflow;
`ifdef OFMAP_WRITER_STAT_EN
  logic [31:0]  stall_cycles;
`endif

  ofmap_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_stall   (in_stall),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ready (sram_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
`ifdef OFMAP_WRITER_STAT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted beats collect until PACK of them make a word.
  typedef struct {
    logic [15:0]  a;
    logic [127:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] pend[$];
  logic [15:0] t_base;
  int          t_widx;
  int          done_base;
  int          first_word_cyc;

  function automatic void model_beat(logic [31:0] b);
    logic [127:0] w;
    pend.push_back(b);
    if (pend.size() == PACK) begin
      w = '0;
      for (int k = 0; k < PACK; k++) begin
        w = w | ({96'b0, pend[k]} << (32 * k));
      end
      exp_q.push_back('{a: t_base + t_widx[15:0], d: w});
      t_widx++;
      pend.delete();
    end
  endfunction

  // Write monitor / scoreboard
  int           n_wr = 0;
  int           n_done = 0;
  int           first_wen = -1;
  int           last_wr = -1;
  int           done_cyc = -1;
  logic         stl = 1'b0;
  logic [15:0]  stl_a;
  logic [127:0] stl_d;
  wr_t          e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stl) begin
        check("hold_wen", sram_wen, 1'b1);
        check("hold_addr", sram_addr, stl_a);
        check("hold_wdata", sram_wdata, stl_d);
      end
      if (sram_wen && first_wen < 0) first_wen = cyc;
      if (sram_wen && sram_ready) begin
        n_wr++;
        last_wr = cyc;
        check("wr_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", sram_addr, e.a);
          check("wr_data", sram_wdata, e.d);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      stl   = sram_wen && !sram_ready;
      stl_a = sram_addr;
      stl_d = sram_wdata;
    end else begin
      stl = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(logic [15:0] b, logic [15:0] n);
    base_addr = b;
    num_words = n;
    t_base = b;
    t_widx = 0;
    pend.delete();
    first_wen = -1;
    first_word_cyc = -1;
    done_base = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Beat driver; a driver that honours in_stall reacts one cycle late.
  task automatic stream(int n, int keep, bit honor, bit chk_stall, bit fixed);
    int sent = 0;
    int acc = 0;
    int guard = 0;
    bit st_last = 1'b0;
    bit st_now;
    bit seen = 1'b0;
    logic [31:0] b;
    logic [7:0]  k8;
    while (sent < n && guard < 400) begin
      st_now = in_stall;
      if (chk_stall && st_now && !seen) begin
        seen = 1'b1;
        check("stall_rise_words", acc / PACK, DEPTH - 1);
      end
      if (!(honor && st_last)) begin
        if (fixed) begin
          k8 = 8'(4 * sent);
          b = {k8 + 8'd1, k8 + 8'd2, k8 + 8'd3, k8 + 8'd4};
        end else begin
          b = $urandom;
        end
        in_valid = 1'b1;
        in_data = b;
        if (sent < keep) begin
          model_beat(b);
          acc++;
          if (acc == PACK && first_word_cyc < 0) first_word_cyc = cyc;
        end
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      st_last = st_now;
      guard++;
    end
    if (guard >= 400) check("stream_timeout", sent, n);
    if (chk_stall) check("stall_seen", seen, 1'b1);
  endtask

  task automatic wait_done(int maxc);
    int k = 0;
    while (n_done == done_base && k < maxc) begin
      tick();
      k++;
    end
    check("done_count", n_done - done_base, 1);
    check("done_latency", done_cyc - last_wr, 1);
    tick();
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_wen"}, sram_wen, 1'b0);
    check({tag, "_addr"}, sram_addr, 16'h0);
    check({tag, "_wdata"}, sram_wdata, 128'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_stall"}, in_stall, 1'b0);
  endtask

  int w0;

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Basic tile with the fixed beat pattern
    sram_ready = 1'b1;
    w0 = n_wr;
    start_tile(16'h0100, 16'd2);
    check("exp_slot0_lsb", 32'(exp_q.size()), 0);
    stream(8, 8, 1'b0, 1'b0, 1'b1);
    wait_done(20);
    check("first_wr_latency", first_wen - first_word_cyc, 1);
    check("basic_writes", n_wr - w0, 2);
    check("basic_ovf", overflow, 1'b0);

    // Backpressure: SRAM blocked for 20 cycles, driver honours stall
    start_tile(16'($urandom), 16'd5);
    fork
      begin
        sram_ready = 1'b0;
        repeat (20) tick();
        sram_ready = 1'b1;
      end
      stream(20, 20, 1'b1, 1'b1, 1'b0);
    join
    wait_done(100);
    check("bp_ovf", overflow, 1'b0);

    // Overflow: FIFO holds DEPTH words, extra beats are dropped
    start_tile(16'($urandom), 16'd6);
    sram_ready = 1'b0;
    stream(20, 16, 1'b0, 1'b0, 1'b0);
    check("ovf_set", overflow, 1'b1);
    sram_ready = 1'b1;
    stream(8, 8, 1'b1, 1'b0, 1'b0);
    wait_done(100);
    check("ovf_sticky", overflow, 1'b1);

    // Zero-word tile
    w0 = n_wr;
    start_tile(16'h0000, 16'd0);
    check("nw0_done", done, 1'b1);
    check("nw0_busy", busy, 1'b1);
    check("nw0_ovf_clr", overflow, 1'b0);
    tick();
    check("nw0_done_off", done, 1'b0);
    check("nw0_done_cnt", n_done - done_base, 1);
    check("nw0_no_wen", first_wen, -1);
    check("nw0_no_wr", n_wr - w0, 0);

    // Address wrap
    start_tile(16'hFFFF, 16'd2);
    stream(8, 8, 1'b0, 1'b0, 1'b0);
    wait_done(20);

    // Start during RUN is ignored; the 9th beat is excess
    start_tile(16'($urandom), 16'd2);
    stream(3, 3, 1'b0, 1'b0, 1'b0);
    base_addr = 16'hA5A5;
    num_words = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_busy", busy, 1'b1);
    stream(5, 5, 1'b0, 1'b0, 1'b0);
    check("excess_ovf_pre", overflow, 1'b0);
    stream(1, 0, 1'b0, 1'b0, 1'b0);
    check("excess_ovf", overflow, 1'b1);
    wait_done(20);

    // Reset in the middle of a tile
    sram_ready = 1'b0;
    start_tile(16'h3000, 16'd4);
    stream(6, 6, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rst_wen", sram_wen, 1'b1);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    exp_q.delete();
    pend.delete();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midrst_no_done", n_done - done_base, 0);

    // Stall statistics: five blocked write cycles
    start_tile(16'h2000, 16'd1);
    stream(4, 4, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    sram_ready = 1'b1;
    wait_done(20);
`ifdef OFMAP_WRITER_STAT_EN
    check("stall_cycles", stall_cycles, 32'd5);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
